data_sram_responder: RTL and testbench

Responder (slave) end of the CPU's SRAM-like data-memory interface: accepts request handshakes from the EX stage, performs byte-strobed writes and word reads on an internal synchronous RAM, and returns in-order `data_ok`/`rdata` responses a fixed number of cycles later. It sits between the core's data port and on-chip memory. It also serves as the simulation memory model for the MEM/WB response path. A bounded count of outstanding requests and an optional pseudo-random `addr_ok` stall exercise the core's handshake logic.

---
 rtl/sram_if_pkg.sv | 26 ++
 rtl/sram_resp_pipe.sv | 67 ++++++
 rtl/data_sram_responder.sv | 111 +++++++++++
 tb/tb_data_sram_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_if_pkg.sv
// Shared definitions for the SRAM-like data-memory interface.
// Holds the transfer-size encodings, the default geometry of the
// responder, and the stall LFSR seed, taps and step function.
package sram_if_pkg;

  // Transfer size encodings carried on the size field.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Default responder geometry.
  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_LATENCY    = 2;
  localparam int DEF_RAND_STALL = 0;

  // 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  // In the right-shifting form the feedback taps are state bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

endpackage

// File: rtl/sram_resp_pipe.sv
// Response delay line of the data SRAM responder.
// Stage 0 captures {accept, is_read}; its data is the RAM's registered read
// word, zeroed for writes. Stages 1..LATENCY-1 are plain {valid, data} shifts.
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   load          a request is accepted this cycle
//   load_rd       the accepted request is a read
//   ram_q         RAM read register (valid the cycle after a read accept)
//   valid, data   last-stage response (data_ok / rdata)
module sram_resp_pipe #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        load_rd,
  input  logic [31:0] ram_q,
  output logic        valid,
  output logic [31:0] data
);

  logic [LATENCY-1:0]       valid_tap;
  logic [LATENCY-1:0][31:0] data_tap;
  logic                     stage0_valid;
  logic                     stage0_rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage0_valid <= 1'b0;
      stage0_rd    <= 1'b0;
    end else begin
      stage0_valid <= load;
      stage0_rd    <= load_rd;
    end
  end

  // The RAM output register doubles as stage-0 data, so the read costs no
  // extra cycle. It has no reset; masking with stage0_rd keeps rdata at 0
  // for writes, idle cycles and right after reset.
  assign valid_tap[0] = stage0_valid;
  assign data_tap[0]  = stage0_rd ? ram_q : 32'h0;

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_stage
      logic        valid_reg;
      logic [31:0] data_reg;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          valid_reg <= 1'b0;
          data_reg  <= 32'h0;
        end else begin
          valid_reg <= valid_tap[gi-1];
          data_reg  <= data_tap[gi-1];
        end
      end

      assign valid_tap[gi] = valid_reg;
      assign data_tap[gi]  = data_reg;
    end
  endgenerate

  assign valid = valid_tap[LATENCY-1];
  assign data  = data_tap[LATENCY-1];

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU's SRAM-like data-memory interface.
// Accepts one request per cycle (req & addr_ok), performs byte-strobed
// writes / word reads on an internal RAM, and returns in-order one-cycle
// data_ok pulses LATENCY cycles after each accept. The number of accepted
// but unanswered requests is bounded by DEPTH; with RAND_STALL set, addr_ok
// is further gated by a free-running LFSR bit.
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   req, wr       request valid, 1 = write / 0 = read
//   size          transfer size (informational; wstrb selects the lanes)
//   wstrb         byte write enables (writes only)
//   addr          byte address; word index is addr[ADDR_W+1:2]
//   wdata         write data, already replicated onto the right lanes
//   addr_ok       request may be accepted this cycle
//   data_ok       response pulse
//   rdata         read data with data_ok, 0 for write responses
module data_sram_responder
  import sram_if_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int RAND_STALL = DEF_RAND_STALL
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WORDS = 1 << ADDR_W;

  logic [31:0]       mem [WORDS];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              is_read;
  logic              stall_ok;
  logic [CNT_W-1:0]  outstanding;
  logic [15:0]       lfsr;

  // size and the out-of-range address bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign idx      = addr[ADDR_W+1:2];
  assign stall_ok = (RAND_STALL != 0) ? lfsr[0] : 1'b1;
  // Registered count only: a response in the same cycle does not free a slot
  // until the next cycle, which keeps addr_ok independent of data_ok and req.
  assign addr_ok  = (outstanding < CNT_W'(DEPTH)) && stall_ok;
  assign accept   = req & addr_ok;
  assign is_read  = accept & ~wr;

  // RAM: byte-lane writes and a registered read. At most one request is
  // accepted per edge, so a read never races a write to the same word and
  // sees every write accepted on earlier edges.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (is_read) begin
      ram_q <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
    end else begin
      case ({accept, data_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Free-running stall source, advances whether or not a request is present.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  sram_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .load    (accept),
    .load_rd (is_read),
    .ram_q   (ram_q),
    .valid   (data_ok),
    .data    (rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder.
// Three instances: u_a (DEPTH 4, LATENCY 2), u_b (DEPTH 1, LATENCY 3) and
// u_c (DEPTH 4, LATENCY 2, random stall). Inputs change on the falling
// edge; outputs are sampled on the falling edge before new inputs are set.
module tb_data_sram_responder;
  import sram_if_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = SIZE_W;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ok_a, dok_a, ok_b, dok_b, ok_c, dok_c;
  logic [31:0] rd_a, rd_b, rd_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(14), .DEPTH(4), .LATENCY(2), .RAND_STALL(0)) u_a (
    .clk(clk), .resetn(resetn), .req(req_a), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(ok_a), .data_ok(dok_a), .rdata(rd_a));

  data_sram_responder #(.ADDR_W(14), .DEPTH(1), .LATENCY(3), .RAND_STALL(0)) u_b (
    .clk(clk), .resetn(resetn), .req(req_b), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(ok_b), .data_ok(dok_b), .rdata(rd_b));

  data_sram_responder #(.ADDR_W(14), .DEPTH(4), .LATENCY(2), .RAND_STALL(1)) u_c (
    .clk(clk), .resetn(resetn), .req(req_c), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(ok_c), .data_ok(dok_c), .rdata(rd_c));

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (dok_a !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok: got %b want 0", dok_a); end
    n_checks++; if (rd_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rd_a); end
    n_checks++; if (ok_a !== 1'b1) begin n_fail++; $display("FAIL reset_addr_ok_a: got %b want 1", ok_a); end
    n_checks++; if (ok_b !== 1'b1) begin n_fail++; $display("FAIL reset_addr_ok_b: got %b want 1", ok_b); end
    n_checks++; if (ok_c !== 1'b1) begin n_fail++; $display("FAIL reset_addr_ok_stall: got %b want 1", ok_c); end
    n_checks++; if (int'(u_a.outstanding) !== 0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", u_a.outstanding); end
    resetn = 1'b1;
    $display("txn reset released");
  endtask

  // Full-word write then read of 0x10, then a single-byte merge and read.
  task automatic test_write_read;
    logic [3:0]  strb_t [2] = '{4'hF, 4'h4};
    logic [31:0] wd_t   [2] = '{32'hDEADBEEF, 32'h00AA0000};
    logic [31:0] exp_t  [2] = '{32'hDEADBEEF, 32'hDEAABEEF};
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      n_checks++; if (ok_a !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ok: got %b want 1", ok_a); end
      req_a = 1'b1; wr = 1'b1; addr = 32'h10; wstrb = strb_t[p]; wdata = wd_t[p];
      size = (p == 0) ? SIZE_W : SIZE_B;
      @(negedge clk);
      n_checks++; if (dok_a !== 1'b0) begin n_fail++; $display("FAIL early_data_ok: got %b want 0", dok_a); end
      wr = 1'b0; wstrb = 4'h0; size = SIZE_W;
      @(negedge clk);
      req_a = 1'b0;
      n_checks++; if (dok_a !== 1'b1) begin n_fail++; $display("FAIL wr_resp_valid: got %b want 1", dok_a); end
      n_checks++; if (rd_a !== 32'h0) begin n_fail++; $display("FAIL wr_resp_rdata: got %h want 0", rd_a); end
      @(negedge clk);
      n_checks++; if (dok_a !== 1'b1) begin n_fail++; $display("FAIL rd_resp_valid: got %b want 1", dok_a); end
      n_checks++; if (rd_a !== exp_t[p]) begin n_fail++; $display("FAIL rd_resp_data: got %h want %h", rd_a, exp_t[p]); end
      $display("txn write strb=%h data=%h then read 0x10 -> %h", strb_t[p], wd_t[p], rd_a);
      @(negedge clk);
      n_checks++; if (dok_a !== 1'b0) begin n_fail++; $display("FAIL resp_end: got %b want 0", dok_a); end
    end
  endtask

  // DEPTH=1, LATENCY=3, req held high: addr_ok reopens only the cycle after
  // each response, and never more than one request is outstanding.
  task automatic test_depth_limit;
    int          due_q[$];
    int          out = 0;
    int          acc = 0;
    logic        exp_ok, exp_dok;
    logic [31:0] word = 32'h1234_5678;
    @(negedge clk);
    u_b.mem[5] = word;
    req_b = 1'b1; wr = 1'b0; addr = 32'h14;
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge clk);
      exp_dok = (due_q.size() > 0) && (due_q[0] == k);
      exp_ok  = (out < 1);
      n_checks++; if (ok_b !== exp_ok) begin n_fail++; $display("FAIL depth1_addr_ok k=%0d: got %b want %b", k, ok_b, exp_ok); end
      n_checks++; if (dok_b !== exp_dok) begin n_fail++; $display("FAIL depth1_data_ok k=%0d: got %b want %b", k, dok_b, exp_dok); end
      n_checks++; if (int'(u_b.outstanding) !== out) begin n_fail++; $display("FAIL depth1_outstanding k=%0d: got %0d want %0d", k, u_b.outstanding, out); end
      if (exp_dok) begin
        n_checks++; if (rd_b !== word) begin n_fail++; $display("FAIL depth1_rdata k=%0d: got %h want %h", k, rd_b, word); end
        void'(due_q.pop_front());
        out--;
      end
      if (k == 16) req_b = 1'b0;
      if (exp_ok && req_b) begin
        due_q.push_back(k + 3);
        out++;
        acc++;
      end
    end
    $display("txn depth1 accepted %0d requests", acc);
    repeat (4) @(negedge clk);
    n_checks++; if (dok_b !== 1'b0) begin n_fail++; $display("FAIL depth1_drain: got %b want 0", dok_b); end
  endtask

  // Four back-to-back reads of preloaded words, data returned in order.
  task automatic test_back_to_back;
    int          due_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] words [4];
    logic        exp_dok;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      u_a.mem[48 + i] = words[i];
    end
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      exp_dok = (due_q.size() > 0) && (due_q[0] == k);
      n_checks++; if (ok_a !== 1'b1) begin n_fail++; $display("FAIL b2b_addr_ok k=%0d: got %b want 1", k, ok_a); end
      n_checks++; if (dok_a !== exp_dok) begin n_fail++; $display("FAIL b2b_data_ok k=%0d: got %b want %b", k, dok_a, exp_dok); end
      if (exp_dok) begin
        n_checks++; if (rd_a !== dat_q[0]) begin n_fail++; $display("FAIL b2b_rdata k=%0d: got %h want %h", k, rd_a, dat_q[0]); end
        $display("txn b2b read response %h", rd_a);
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      req_a = (k < 4); wr = 1'b0;
      if (k < 4) begin
        addr = 32'(48 + k) << 2;
        due_q.push_back(k + 2);
        dat_q.push_back(words[k]);
      end
    end
  endtask

  // Reset while two reads are in flight drops both responses.
  task automatic test_reset_inflight;
    logic [31:0] w0 = $urandom;
    logic [31:0] w1 = $urandom;
    @(negedge clk);
    u_a.mem[32] = w0;
    u_a.mem[33] = w1;
    req_a = 1'b1; wr = 1'b0; addr = 32'h80;
    @(negedge clk);
    addr = 32'h84;
    @(negedge clk);
    req_a = 1'b0;
    n_checks++; if (dok_a !== 1'b1) begin n_fail++; $display("FAIL inflight_first_valid: got %b want 1", dok_a); end
    n_checks++; if (rd_a !== w0) begin n_fail++; $display("FAIL inflight_first_data: got %h want %h", rd_a, w0); end
    #1 resetn = 1'b0;
    #1;
    n_checks++; if (dok_a !== 1'b0) begin n_fail++; $display("FAIL inflight_reset_data_ok: got %b want 0", dok_a); end
    n_checks++; if (rd_a !== 32'h0) begin n_fail++; $display("FAIL inflight_reset_rdata: got %h want 0", rd_a); end
    n_checks++; if (int'(u_a.outstanding) !== 0) begin n_fail++; $display("FAIL inflight_reset_outstanding: got %0d want 0", u_a.outstanding); end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (dok_a !== 1'b0) begin n_fail++; $display("FAIL inflight_stale_pulse k=%0d: got %b want 0", k, dok_a); end
    end
    n_checks++; if (int'(u_a.outstanding) !== 0) begin n_fail++; $display("FAIL inflight_outstanding_after: got %0d want 0", u_a.outstanding); end
    $display("txn reset with two reads in flight");
  endtask

  // 1000 random requests against a stalling responder, checked against a
  // word-array scoreboard and an expected-response queue.
  task automatic test_random_stall;
    logic [31:0] shadow [64];
    int          due_q[$];
    logic [31:0] dat_q[$];
    int          out = 0;
    int          acc = 0;
    int          k = 0;
    int          idx;
    logic [15:0] lf = 16'hACE1;
    logic        fb, exp_ok, exp_dok;
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 64; i++) begin
      shadow[i] = $urandom;
      u_c.mem[i] = shadow[i];
    end
    @(negedge clk);
    resetn = 1'b1;
    while (1) begin
      exp_dok = (due_q.size() > 0) && (due_q[0] == k);
      exp_ok  = (out < 4) && lf[0];
      n_checks++; if (ok_c !== exp_ok) begin n_fail++; $display("FAIL rand_addr_ok k=%0d: got %b want %b", k, ok_c, exp_ok); end
      n_checks++; if (dok_c !== exp_dok) begin n_fail++; $display("FAIL rand_data_ok k=%0d: got %b want %b", k, dok_c, exp_dok); end
      if (exp_dok) begin
        n_checks++; if (rd_c !== dat_q[0]) begin n_fail++; $display("FAIL rand_rdata k=%0d: got %h want %h", k, rd_c, dat_q[0]); end
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
        out--;
      end
      if (acc < 1000) begin
        req_c = ($urandom_range(0, 3) != 0);
        wr    = $urandom_range(0, 1) == 1;
        wstrb = 4'($urandom);
        wdata = $urandom;
        idx   = $urandom_range(0, 63);
        addr  = {16'($urandom), 8'h0, 6'(idx), 2'($urandom)};
      end else begin
        req_c = 1'b0;
      end
      if (req_c && exp_ok) begin
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
          dat_q.push_back(32'h0);
        end else begin
          dat_q.push_back(shadow[idx]);
        end
        due_q.push_back(k + 2);
        out++;
        acc++;
      end
      fb = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
      lf = {fb, lf[15:1]};
      k++;
      if ((acc >= 1000 && due_q.size() == 0) || k > 20000) break;
      @(negedge clk);
    end
    n_checks++; if (acc != 1000 || due_q.size() != 0) begin n_fail++; $display("FAIL rand_timeout: got %0d accepts %0d pending want 1000 accepts 0 pending", acc, due_q.size()); end
    @(negedge clk);
    n_checks++; if (dok_c !== 1'b0) begin n_fail++; $display("FAIL rand_drain: got %b want 0", dok_c); end
    $display("txn random stall run: %0d accepts over %0d cycles", acc, k);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_depth_limit();
    test_back_to_back();
    test_reset_inflight();
    test_random_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
